// File: rtl/uart_rx_fsm_if.sv
// Signal bundle between the UART receive frame controller and its
// sampler, deserializer and start/parity/stop check units.
interface uart_rx_fsm_if #(
    parameter int PRESCALE_W = 6
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic [PRESCALE_W-1:0] Prescale;
    logic                  sampled_bit;
    logic                  strt_glitch;
    logic                  par_err;
    logic                  stp_err;

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [3:0]            bit_cnt;
    logic                  dat_samp_en;
    logic                  deser_en;
    logic                  strt_chk_en;
    logic                  par_chk_en;
    logic                  stp_chk_en;
    logic                  data_valid;

    // The frame controller owns the counters and strobes.
    modport master (
        input  RX_IN, PAR_EN, Prescale, sampled_bit,
        input  strt_glitch, par_err, stp_err,
        output edge_cnt, bit_cnt, dat_samp_en, deser_en,
        output strt_chk_en, par_chk_en, stp_chk_en, data_valid
    );

    modport slave (
        output RX_IN, PAR_EN, Prescale, sampled_bit,
        output strt_glitch, par_err, stp_err,
        input  edge_cnt, bit_cnt, dat_samp_en, deser_en,
        input  strt_chk_en, par_chk_en, stp_chk_en, data_valid
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: start detection, oversample/bit counting,
// check-unit strobes and frame qualification.
//
//   state  | meaning
//   IDLE   | line idle, counters held at 0, waiting for RX_IN low
//   START  | start bit; strt_chk_en at CHK, glitch aborts to IDLE
//   DATA   | data bits 1..DATA_BITS; deser_en at CHK of each bit
//   PARITY | parity bit (only when latched PAR_EN); par_chk_en at CHK
//   STOP   | stop bit; stp_chk_en at CHK, data_valid at LAST if no error
module uart_rx_fsm #(
    parameter int DATA_BITS  = 8,
    parameter int PRESCALE_W = 6
) (
    input logic          CLK,
    input logic          RST,
    uart_rx_fsm_if.master bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]            state, state_nx;
    logic [PRESCALE_W-1:0] edge_q, edge_nx;
    logic [3:0]            bit_q, bit_nx;
    logic [PRESCALE_W-1:0] ps_q, ps_nx, ps_dec;
    logic                  pe_q, pe_nx;
    logic                  err_q, err_nx;
    logic                  samp_q;

    logic [PRESCALE_W-1:0] last_edge;
    logic [PRESCALE_W-1:0] chk_edge;
    logic                  at_last;
    logic                  at_chk;

    // Only 16 and 32 are honoured; anything else falls back to 8x.
    always_comb begin
        ps_dec = PRESCALE_W'(8);
        if (bus.Prescale == PRESCALE_W'(16))
            ps_dec = PRESCALE_W'(16);
        else if (bus.Prescale == PRESCALE_W'(32))
            ps_dec = PRESCALE_W'(32);
    end

    assign last_edge = ps_q - PRESCALE_W'(1);
    assign chk_edge  = (ps_q >> 1) + PRESCALE_W'(2);
    assign at_last   = (edge_q == last_edge);
    assign at_chk    = (edge_q == chk_edge);

    always_comb begin
        state_nx = state;
        edge_nx  = edge_q;
        bit_nx   = bit_q;
        ps_nx    = ps_q;
        pe_nx    = pe_q;
        err_nx   = err_q;

        if (state != IDLE) begin
            if (at_last) begin
                edge_nx = '0;
                bit_nx  = bit_q + 4'd1;
            end else begin
                edge_nx = edge_q + PRESCALE_W'(1);
            end
        end

        case (state)
            IDLE: begin
                edge_nx = '0;
                bit_nx  = '0;
                if (!bus.RX_IN) begin
                    state_nx = START;
                    ps_nx    = ps_dec;
                    pe_nx    = bus.PAR_EN;
                    err_nx   = 1'b0;
                end
            end
            START: begin
                if (at_chk && bus.strt_glitch) begin
                    state_nx = IDLE;
                    edge_nx  = '0;
                    bit_nx   = '0;
                end else if (at_last) begin
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (at_last && (bit_q == 4'(DATA_BITS)))
                    state_nx = pe_q ? PARITY : STOP;
            end
            PARITY: begin
                if (at_chk)
                    err_nx = bus.par_err;
                if (at_last)
                    state_nx = STOP;
            end
            STOP: begin
                if (at_chk)
                    err_nx = err_q | bus.stp_err;
                if (at_last) begin
                    edge_nx = '0;
                    bit_nx  = '0;
                    // A low line on the last stop edge is the next start bit.
                    if (!bus.RX_IN) begin
                        state_nx = START;
                        ps_nx    = ps_dec;
                        pe_nx    = bus.PAR_EN;
                        err_nx   = 1'b0;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                edge_nx  = '0;
                bit_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= IDLE;
            edge_q <= '0;
            bit_q  <= '0;
            ps_q   <= '0;
            pe_q   <= 1'b0;
            err_q  <= 1'b0;
            samp_q <= 1'b0;
        end else begin
            state  <= state_nx;
            edge_q <= edge_nx;
            bit_q  <= bit_nx;
            ps_q   <= ps_nx;
            pe_q   <= pe_nx;
            err_q  <= err_nx;
            samp_q <= (state_nx != IDLE);
        end
    end

    assign bus.edge_cnt    = edge_q;
    assign bus.bit_cnt     = bit_q;
    assign bus.dat_samp_en = samp_q;
    assign bus.strt_chk_en = (state == START)  && at_chk;
    assign bus.deser_en    = (state == DATA)   && at_chk;
    assign bus.par_chk_en  = (state == PARITY) && at_chk;
    assign bus.stp_chk_en  = (state == STOP)   && at_chk;
    assign bus.data_valid  = (state == STOP) && at_last &&
                             !(err_q || (at_chk && bus.stp_err));

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: a frame-timeline model compared
// every cycle, plus literal checks on pulse positions and frame lengths.
module tb_uart_rx_fsm;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    uart_rx_fsm_if #(.PRESCALE_W(6)) bus ();

    uart_rx_fsm #(.DATA_BITS(8), .PRESCALE_W(6)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    function automatic int dec_ps(input int p);
        return (p == 16) ? 16 : (p == 32) ? 32 : 8;
    endfunction

    // Model: a frame is an offset k from START entry; bit = k/ps, edge = k%ps.
    int m_k   = 0;
    int m_ps  = 8;
    bit m_act = 1'b0;
    bit m_pe  = 1'b0;
    bit m_err = 1'b0;

    function automatic int frame_len(input int ps, input bit pe);
        return (10 + int'(pe)) * ps;
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_act <= 1'b0;
            m_k   <= 0;
            m_err <= 1'b0;
        end else if (!m_act) begin
            if (!bus.RX_IN) begin
                m_act <= 1'b1;
                m_k   <= 0;
                m_ps  <= dec_ps(int'(bus.Prescale));
                m_pe  <= bus.PAR_EN;
                m_err <= 1'b0;
            end
        end else if ((m_k / m_ps == 0) && (m_k % m_ps == m_ps / 2 + 2) && bus.strt_glitch) begin
            m_act <= 1'b0;
        end else if (m_k == frame_len(m_ps, m_pe) - 1) begin
            if (!bus.RX_IN) begin
                m_k   <= 0;
                m_ps  <= dec_ps(int'(bus.Prescale));
                m_pe  <= bus.PAR_EN;
                m_err <= 1'b0;
            end else begin
                m_act <= 1'b0;
            end
        end else begin
            m_k <= m_k + 1;
            if ((m_k % m_ps == m_ps / 2 + 2) && m_pe && (m_k / m_ps == 9))
                m_err <= bus.par_err;
            if ((m_k % m_ps == m_ps / 2 + 2) && (m_k / m_ps == 9 + int'(m_pe)))
                m_err <= m_err | bus.stp_err;
        end
    end

    int e_bit, e_edge, cyc;
    bit e_chk;
    int start_cyc, dv_cyc, d_first, d_last;
    int n_dv, n_deser, n_par, n_stp, n_strt, n_b2b;
    int dv_bit, dv_edge, par_bit, par_edge, deser_edge;
    bit prev_dv;
    logic [7:0] cap;

    initial begin
        cyc = 0; n_dv = 0; n_deser = 0; n_par = 0; n_stp = 0; n_strt = 0; n_b2b = 0;
        start_cyc = 0; dv_cyc = 0; d_first = -1; d_last = 0; prev_dv = 1'b0; cap = 8'h00;
        dv_bit = 0; dv_edge = 0; par_bit = 0; par_edge = 0; deser_edge = 0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (chk_on) begin
                e_bit  = m_act ? m_k / m_ps : 0;
                e_edge = m_act ? m_k % m_ps : 0;
                e_chk  = m_act && (e_edge == m_ps / 2 + 2);
                check("edge_cnt",    int'(bus.edge_cnt),    e_edge);
                check("bit_cnt",     int'(bus.bit_cnt),     e_bit);
                check("dat_samp_en", int'(bus.dat_samp_en), int'(m_act));
                check("strt_chk_en", int'(bus.strt_chk_en), int'(e_chk && e_bit == 0));
                check("deser_en",    int'(bus.deser_en),    int'(e_chk && e_bit >= 1 && e_bit <= 8));
                check("par_chk_en",  int'(bus.par_chk_en),  int'(e_chk && m_pe && e_bit == 9));
                check("stp_chk_en",  int'(bus.stp_chk_en),  int'(e_chk && e_bit == 9 + int'(m_pe)));
                check("data_valid",  int'(bus.data_valid),
                      int'(m_act && m_k == frame_len(m_ps, m_pe) - 1 && !m_err));
            end
            if (bus.dat_samp_en && bus.bit_cnt == 4'd0 && bus.edge_cnt == '0) begin
                start_cyc = cyc;
                d_first   = -1;
                if (prev_dv) n_b2b++;
            end
            if (bus.deser_en) begin
                n_deser++;
                if (d_first < 0) d_first = cyc;
                d_last     = cyc;
                deser_edge = int'(bus.edge_cnt);
                cap        = {bus.sampled_bit, cap[7:1]};
            end
            if (bus.strt_chk_en) n_strt++;
            if (bus.stp_chk_en)  n_stp++;
            if (bus.par_chk_en) begin
                n_par++;
                par_bit  = int'(bus.bit_cnt);
                par_edge = int'(bus.edge_cnt);
            end
            if (bus.data_valid) begin
                n_dv++;
                dv_cyc  = cyc;
                dv_bit  = int'(bus.bit_cnt);
                dv_edge = int'(bus.edge_cnt);
            end
            prev_dv = bus.data_valid;
        end
    end

    // Drives one frame on the line; Prescale may be rewritten at bit index chg_at.
    task automatic drive_frame(input logic [7:0] d, input int ps, input bit with_par,
                               input int chg_at, input int new_ps);
        logic [10:0] bits;
        int nb;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        if (with_par) bits[9] = ^d;
        nb = with_par ? 11 : 10;
        for (int i = 0; i < nb; i++) begin
            if (i == chg_at) bus.Prescale = 6'(new_ps);
            bus.RX_IN       = bits[i];
            bus.sampled_bit = bits[i];
            repeat (ps) tick();
        end
    endtask

    task automatic idle_line(input int n);
        bus.RX_IN       = 1'b1;
        bus.sampled_bit = 1'b1;
        repeat (n) tick();
    endtask

    int s_dv, s_deser, s_par, s_stp, s_strt, s_b2b;

    task automatic snap;
        s_dv = n_dv; s_deser = n_deser; s_par = n_par;
        s_stp = n_stp; s_strt = n_strt; s_b2b = n_b2b;
    endtask

    initial begin
        bus.RX_IN = 1'b1; bus.sampled_bit = 1'b1; bus.PAR_EN = 1'b0;
        bus.Prescale = 6'd8; bus.strt_glitch = 1'b0;
        bus.par_err = 1'b0; bus.stp_err = 1'b0;
        #3 RST = 1'b0;
        chk_on = 1'b1;
        #1;
        check("reset_dat_samp_en", int'(bus.dat_samp_en), 0);
        check("reset_data_valid",  int'(bus.data_valid),  0);
        check("reset_bit_cnt",     int'(bus.bit_cnt),     0);
        #20 RST = 1'b1;
        idle_line(4);

        // PS=8, PE=0, 0xA5
        snap();
        drive_frame(8'hA5, 8, 1'b0, -1, 0);
        idle_line(4);
        check("t1_deser_count", n_deser - s_deser, 8);
        check("t1_deser_span",  d_last - d_first, 56);
        check("t1_deser_edge",  deser_edge, 6);
        check("t1_byte",        int'(cap), 'hA5);
        check("t1_dv_count",    n_dv - s_dv, 1);
        check("t1_frame_len",   dv_cyc - start_cyc + 1, 80);
        check("t1_par_count",   n_par - s_par, 0);

        // PS=16, PE=1, 0x3C even parity
        snap();
        bus.Prescale = 6'd16; bus.PAR_EN = 1'b1;
        drive_frame(8'h3C, 16, 1'b1, -1, 0);
        idle_line(4);
        check("t2_par_count", n_par - s_par, 1);
        check("t2_par_bit",   par_bit, 9);
        check("t2_par_edge",  par_edge, 10);
        check("t2_dv_count",  n_dv - s_dv, 1);
        check("t2_dv_bit",    dv_bit, 10);
        check("t2_dv_edge",   dv_edge, 15);
        check("t2_byte",      int'(cap), 'h3C);
        check("t2_frame_len", dv_cyc - start_cyc + 1, 176);

        // start glitch
        snap();
        bus.Prescale = 6'd8; bus.PAR_EN = 1'b0; bus.strt_glitch = 1'b1;
        bus.RX_IN = 1'b0; bus.sampled_bit = 1'b0;
        repeat (3) tick();
        idle_line(12);
        bus.strt_glitch = 1'b0;
        check("t3_strt_count",  n_strt - s_strt, 1);
        check("t3_deser_count", n_deser - s_deser, 0);
        check("t3_dv_count",    n_dv - s_dv, 0);
        check("t3_idle_samp",   int'(bus.dat_samp_en), 0);
        check("t3_idle_edge",   int'(bus.edge_cnt), 0);

        // parity error, stop error, then a clean frame
        snap();
        bus.PAR_EN = 1'b1; bus.par_err = 1'b1;
        drive_frame(8'h81, 8, 1'b1, -1, 0);
        idle_line(4);
        bus.par_err = 1'b0;
        check("t4_par_stp_count", n_stp - s_stp, 1);
        check("t4_par_dv_count",  n_dv - s_dv, 0);
        snap();
        bus.PAR_EN = 1'b0; bus.stp_err = 1'b1;
        drive_frame(8'h7E, 8, 1'b0, -1, 0);
        idle_line(4);
        bus.stp_err = 1'b0;
        check("t4_stp_stp_count", n_stp - s_stp, 1);
        check("t4_stp_dv_count",  n_dv - s_dv, 0);
        snap();
        drive_frame(8'h42, 8, 1'b0, -1, 0);
        idle_line(4);
        check("t4_clean_dv_count", n_dv - s_dv, 1);

        // back-to-back, Prescale 8 -> 16 during frame 1
        snap();
        bus.Prescale = 6'd8;
        drive_frame(8'h5A, 8, 1'b0, 3, 16);
        drive_frame(8'hC3, 16, 1'b0, -1, 0);
        idle_line(4);
        check("t5_dv_count",    n_dv - s_dv, 2);
        check("t5_b2b_count",   n_b2b - s_b2b, 1);
        check("t5_frame2_len",  dv_cyc - start_cyc + 1, 160);
        check("t5_frame2_byte", int'(cap), 'hC3);

        // async reset at bit 4, edge 3 of a PS=8 frame
        snap();
        bus.Prescale = 6'd8;
        bus.RX_IN = 1'b0; bus.sampled_bit = 1'b0;
        tick();
        repeat (35) tick();
        check("t6_pre_bit",  int'(bus.bit_cnt), 4);
        check("t6_pre_edge", int'(bus.edge_cnt), 3);
        RST = 1'b0;
        #1;
        check("t6_rst_samp",  int'(bus.dat_samp_en), 0);
        check("t6_rst_bit",   int'(bus.bit_cnt), 0);
        check("t6_rst_edge",  int'(bus.edge_cnt), 0);
        check("t6_rst_strb",  int'({bus.deser_en, bus.strt_chk_en, bus.par_chk_en,
                                     bus.stp_chk_en, bus.data_valid}), 0);
        bus.RX_IN = 1'b1; bus.sampled_bit = 1'b1;
        #1 RST = 1'b1;
        idle_line(20);
        check("t6_idle_samp", int'(bus.dat_samp_en), 0);
        check("t6_dv_count",  n_dv - s_dv, 0);
        bus.strt_glitch = 1'b1;
        bus.RX_IN = 1'b0; bus.sampled_bit = 1'b0;
        tick();
        check("t6_restart_samp", int'(bus.dat_samp_en), 1);
        idle_line(12);
        bus.strt_glitch = 1'b0;
        check("t6_end_samp", int'(bus.dat_samp_en), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
Frame controller for the UART receiver. It detects the start bit on RX_IN and runs the per-bit oversampling edge counter and the frame bit counter. It issues one-cycle enable strobes to the data sampler, the deserializer, and the start/parity/stop check units, then qualifies the frame with data_valid. The deserializer writes P_DATA[bit_cnt-1] while deser_en is high, so bit_cnt equals 1..8 during data bits.

Parameters:
DATA_BITS, 8, number of data bits per frame (bit_cnt width is 4).
PRESCALE_W, 6, width of the Prescale input and edge_cnt.

Ports:
CLK  input  1  receiver clock (oversampling clock)
RST  input  1  asynchronous active-low reset
RX_IN  input  1  serial line, idle high (synchronised upstream)
PAR_EN  input  1  parity bit present in frame
Prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32
sampled_bit  input  1  majority-voted bit from sampler
strt_glitch  input  1  start checker result, valid while strt_chk_en=1
par_err  input  1  parity checker result, valid while par_chk_en=1
stp_err  input  1  stop checker result, valid while stp_chk_en=1
edge_cnt  output  PRESCALE_W  oversample edge index within current bit
bit_cnt  output  4  frame bit index (0=start, 1..8 data, 9 parity/stop, 10 stop)
dat_samp_en  output  1  sampler enable
deser_en  output  1  deserializer write strobe
strt_chk_en  output  1  start check strobe
par_chk_en  output  1  parity check strobe
stp_chk_en  output  1  stop check strobe
data_valid  output  1  one-cycle pulse, frame received error-free

Behaviour:
- Reset (async, RST=0): state IDLE; every output and internal register is 0.
- Latched config (PS, PE): Prescale and PAR_EN are captured on the IDLE->START transition and held for the whole frame. Mid-frame changes are ignored. Prescale values other than 16 or 32 are treated as 8.
- Derived constants: CHK = PS/2 + 2 (checker strobe edge). LAST = PS-1.
- States: IDLE, START, DATA, PARITY, STOP.
- Counting:
  - In any non-IDLE state, edge_cnt increments every cycle.
  - At edge_cnt==LAST, edge_cnt wraps to 0 and bit_cnt increments.
  - In IDLE, edge_cnt=0 and bit_cnt=0.
- dat_samp_en = 1 in every state except IDLE (registered, same cycle as state).
- Strobes: a strobe is high for exactly one cycle, when edge_cnt==CHK in its state.
  - START -> strt_chk_en.
  - DATA -> deser_en.
  - PARITY -> par_chk_en.
  - STOP -> stp_chk_en.
- IDLE: RX_IN==0 -> START next cycle with edge_cnt=0, bit_cnt=0.
- START:
  - On the strt_chk_en cycle with strt_glitch=1 -> IDLE next cycle (counters cleared, no further strobes).
  - At edge_cnt==LAST -> DATA, bit_cnt=1.
- DATA: at edge_cnt==LAST with bit_cnt==DATA_BITS -> PARITY if PE else STOP.
- PARITY: on the par_chk_en cycle, latch par_err into an internal error flag (flag cleared on entering START).
- STOP:
  - On the stp_chk_en cycle, OR stp_err into the error flag.
  - At edge_cnt==LAST: data_valid=1 for that one cycle iff error flag==0 (including that cycle's stp_err).
  - Next state is START if RX_IN==0 in that cycle (back-to-back frame, PS/PE re-latched), else IDLE.
- Errors do not abort the frame; only a start glitch aborts.
- data_valid never asserts outside STOP; an aborted or errored frame produces no pulse.
- Frame length: (1+DATA_BITS+PE+1)*PS cycles from START entry to the data_valid cycle inclusive.
- Async reset mid-frame returns to IDLE immediately; a partial frame never raises data_valid.

Test Plan:
- PS=8, PE=0, frame 0xA5 LSB-first, sampled_bit tracks line: deser_en pulses at edge 6 of bits 1..8 (8 pulses, 8 cycles apart); data_valid pulses at cycle 80 after START entry; no par_chk_en.
- PS=16, PE=1, even-parity frame 0x3C, par_err=0, stp_err=0: par_chk_en pulses once at bit_cnt=9, edge 10; data_valid pulses once at bit_cnt=10, edge 15.
- PS=8, RX_IN low for 3 cycles only, strt_glitch=1 at edge 6: FSM in IDLE next cycle; no deser_en; no data_valid; edge_cnt=bit_cnt=0.
- PS=8, PE=1, par_err=1 at parity strobe (or stp_err=1 at stop strobe): frame runs to completion; data_valid stays 0; the next clean frame yields data_valid=1.
- Two back-to-back frames, RX_IN=0 at the stop-bit LAST edge, Prescale changed 8->16 during frame 1: second frame enters START directly (no IDLE cycle) and uses PS=16; each frame produces one data_valid.
- Assert RST low at bit_cnt=4, edge 3 of a PS=8 frame: all outputs 0 immediately; after release, FSM in IDLE until RX_IN falls.
